// File: rtl/divisibility_by7_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : divisibility_by7_tx                                           |
// | Description : Mod-7 residue link transmitter. Serializes a DATA_W-bit word  |
// |               MSB-first and appends a 3-bit check field so the whole frame, |
// |               read as an unsigned number, is divisible by 7.                |
// | Options     : DIV7_TX_CHECK_EN - build the CHECK phase. When undefined the  |
// |               block is a plain MSB-first serializer whose rem output ends   |
// |               each frame at D mod 7.                                        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module divisibility_by7_tx #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   output logic              ready,
   output logic              sout,
   output logic              sout_valid,
   output logic              done,
   output logic [2:0]        rem
);

   // Counter must reach DATA_W-1 in DATA and 2 in CHECK.
   localparam int CNT_W = ($clog2(DATA_W + 1) > 2) ? $clog2(DATA_W + 1) : 2;
   localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_W - 1);
`ifdef DIV7_TX_CHECK_EN
   localparam logic [CNT_W-1:0] LAST_CHECK = CNT_W'(2);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [2:0]          rem_q,   rem_d;
`ifdef DIV7_TX_CHECK_EN
   logic [2:0]          chk_q,   chk_d;
`endif
   logic                bit_out;
   logic                bit_valid;
   logic                frame_last;

   // One step of the residue recurrence: (2*r + b) mod 7, kept inside 0..6.
   function automatic logic [2:0] mod7_step(input logic [2:0] r, input logic b);
      logic [3:0] t;
      t = {r, 1'b0} + {3'b000, b};
      if (t >= 4'd7) begin
         t = t - 4'd7;
      end
      return t[2:0];
   endfunction

`ifdef DIV7_TX_CHECK_EN
   // Check value that drives the residue to zero after three more bits:
   // 8*r + c == 0 (mod 7)  <=>  c == -r (mod 7).
   function automatic logic [2:0] check_of(input logic [2:0] r);
      return (r == 3'd0) ? 3'd0 : (3'd7 - r);
   endfunction
`endif

   // Next-state, datapath update and bit emission for the current cycle.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
`ifdef DIV7_TX_CHECK_EN
      chk_d      = chk_q;
`endif
      bit_out    = 1'b0;
      bit_valid  = 1'b0;
      frame_last = 1'b0;

      case (state_q)
         IDLE: begin
            // Acceptance handled below together with the end-of-frame case.
         end
         DATA: begin
            bit_valid = 1'b1;
            bit_out   = shreg_q[DATA_W-1];
            shreg_d   = shreg_q << 1;
            cnt_d     = cnt_q + CNT_W'(1);
            rem_d     = mod7_step(rem_q, bit_out);
            if (cnt_q == LAST_DATA) begin
`ifdef DIV7_TX_CHECK_EN
               cnt_d   = '0;
               chk_d   = check_of(rem_d);
               state_d = CHECK;
`else
               frame_last = 1'b1;
`endif
            end
         end
`ifdef DIV7_TX_CHECK_EN
         CHECK: begin
            bit_valid = 1'b1;
            bit_out   = chk_q[2];
            chk_d     = {chk_q[1:0], 1'b0};
            cnt_d     = cnt_q + CNT_W'(1);
            rem_d     = mod7_step(rem_q, bit_out);
            if (cnt_q == LAST_CHECK) begin
               frame_last = 1'b1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new frame may start from IDLE or directly after the last bit,
      // which gives gap-free back-to-back frames.
      if (load && ((state_q == IDLE) || frame_last)) begin
         shreg_d = din;
         cnt_d   = '0;
         rem_d   = 3'd0;
         state_d = DATA;
      end else if (frame_last) begin
         cnt_d   = '0;
         state_d = IDLE;
      end
   end

   // State and datapath registers; reset abandons any frame in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         rem_q   <= 3'd0;
`ifdef DIV7_TX_CHECK_EN
         chk_q   <= 3'd0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
`ifdef DIV7_TX_CHECK_EN
         chk_q   <= chk_d;
`endif
      end
   end

   assign ready      = (state_q == IDLE) || frame_last;
   assign sout       = bit_out;
   assign sout_valid = bit_valid;
   assign done       = frame_last;
   assign rem        = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_divisibility_by7_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_divisibility_by7_tx                                        |
// | Description : Directed self-checking bench for divisibility_by7_tx,         |
// |               DATA_W = 8. Expectations follow DIV7_TX_CHECK_EN.             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_divisibility_by7_tx;

   localparam int DATA_W = 8;
`ifdef DIV7_TX_CHECK_EN
   localparam int FL = DATA_W + 3;
`else
   localparam int FL = DATA_W;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic [7:0] din;
   logic       ready;
   logic       sout;
   logic       sout_valid;
   logic       done;
   logic [2:0] rem;

   int n_checks = 0;
   int n_fail   = 0;

   divisibility_by7_tx #(.DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .din        (din),
      .ready      (ready),
      .sout       (sout),
      .sout_valid (sout_valid),
      .done       (done),
      .rem        (rem)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_frame(input logic [7:0] d, input logic [2:0] c);
`ifdef DIV7_TX_CHECK_EN
      return {21'd0, d, c};
`else
      return {24'd0, d} | ({29'd0, c} & 32'd0);
`endif
   endfunction

   // Wait (bounded) for ready, then present one accepted load.
   task automatic start(input logic [7:0] d);
      int n = 0;
      while (!ready && n < 20) begin
         tick();
         n++;
      end
      if (!ready) check_eq("ready_timeout", {31'd0, ready}, 32'd1);
      load = 1'b1;
      din  = d;
      tick();
      load = 1'b0;
      din  = ~d;
   endtask

   // Observe cycles 1..FL of a frame; at the last bit optionally chain a new load.
   task automatic collect(input logic chain, input logic [7:0] nd,
                          output logic [31:0] bits, output int done_at,
                          output int n_done, output int nvalid,
                          output int chk_rem, output logic [2:0] rem_last);
      int r;
      r        = 0;
      bits     = 0;
      done_at  = 0;
      n_done   = 0;
      nvalid   = 0;
      chk_rem  = -1;
      rem_last = 3'd7;
      for (int k = 1; k <= FL; k++) begin
         bits = {bits[30:0], sout};
         if (sout_valid) nvalid++;
         r = (2 * r + int'(sout)) % 7;
         if (done) begin
            n_done++;
            if (done_at == 0) done_at = k;
            chk_rem = r;
         end
         if (k == FL) begin
            rem_last = rem;
            load     = chain;
            din      = nd;
         end
         tick();
      end
      load = 1'b0;
   endtask

   // Full isolated frame with check bits c and final residue r (D mod 7).
   task automatic run_frame(input logic [7:0] d, input logic [2:0] c,
                            input logic [2:0] r, input string tag);
      logic [31:0] bits, ef;
      int done_at, n_done, nvalid, chk_rem;
      logic [2:0] rem_last;
      logic [2:0] fin;
`ifdef DIV7_TX_CHECK_EN
      fin = 3'd0;
`else
      fin = r;
`endif
      ef = exp_frame(d, c);
      start(d);
      collect(1'b0, 8'h00, bits, done_at, n_done, nvalid, chk_rem, rem_last);
      check_eq({tag, "_bits"},    bits, ef);
      check_eq({tag, "_valid"},   nvalid, FL);
      check_eq({tag, "_done_at"}, done_at, FL);
      check_eq({tag, "_ndone"},   n_done, 1);
      check_eq({tag, "_checker"}, chk_rem, {29'd0, fin});
      check_eq({tag, "_rem_last"}, {29'd0, rem_last}, (ef >> 1) % 7);
      check_eq({tag, "_idle"}, {28'd0, ready, sout_valid, sout, done}, 32'h8);
      check_eq({tag, "_rem_end"}, {29'd0, rem}, {29'd0, fin});
   endtask

   initial begin : main
      logic [31:0] bits, bits2;
      int done_at, n_done, nvalid, chk_rem;
      int done_at2, n_done2, nvalid2, chk_rem2;
      logic [2:0] rem_last;
      logic [4:0] part;

      load  = 1'b0;
      din   = 8'h00;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;

      // Reset values, held and after release.
      tick();
      tick();
      check_eq("rst_held", {25'd0, ready, sout_valid, sout, done, rem}, 32'h40);
      rst_n = 1'b1;
      tick();
      check_eq("rst_rel", {25'd0, ready, sout_valid, sout, done, rem}, 32'h40);
      tick();
      tick();
      tick();
      check_eq("rst_idle", {25'd0, ready, sout_valid, sout, done, rem}, 32'h40);

      // Directed frames: (din, check bits, din mod 7), all hand-computed.
      run_frame(8'h0A, 3'd4, 3'd3, "f0A");   // 84  = 12*7
      run_frame(8'hFF, 3'd4, 3'd3, "fFF");   // 2044 = 292*7
      run_frame(8'h07, 3'd0, 3'd0, "f07");   // 56
      run_frame(8'h00, 3'd0, 3'd0, "f00");
      run_frame(8'h05, 3'd2, 3'd5, "f05");   // 42

      // Back-to-back: load held high, 0x0A then 0x05 chained at the last bit.
      load = 1'b1;
      din  = 8'h0A;
      tick();
      collect(1'b1, 8'h05, bits, done_at, n_done, nvalid, chk_rem, rem_last);
      check_eq("b2b_first_bit_valid", {31'd0, sout_valid}, 32'd1);
      collect(1'b0, 8'h00, bits2, done_at2, n_done2, nvalid2, chk_rem2, rem_last);
      check_eq("b2b_bits1",  bits,  exp_frame(8'h0A, 3'd4));
      check_eq("b2b_bits2",  bits2, exp_frame(8'h05, 3'd2));
      check_eq("b2b_nvalid", nvalid + nvalid2, 2 * FL);
      check_eq("b2b_done1",  done_at, FL);
      check_eq("b2b_done2",  FL + done_at2, 2 * FL);
      check_eq("b2b_ndone",  n_done + n_done2, 2);
      check_eq("b2b_idle",   {31'd0, sout_valid}, 32'd0);

      // Ignored load in cycle 4, then reset in cycle 6.
      start(8'h0A);
      part = 5'd0;
      for (int k = 1; k <= 5; k++) begin
         part = {part[3:0], sout};
         if (k == 4) begin
            load = 1'b1;
            din  = 8'h55;
         end
         tick();
         load = 1'b0;
      end
      check_eq("ign_bits", {27'd0, part}, 32'h01);
      check_eq("ign_rem6", {29'd0, rem}, 32'd1);
      check_eq("ign_valid6", {31'd0, sout_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("midrst", {25'd0, ready, sout_valid, sout, done, rem}, 32'h40);
      tick();
      check_eq("midrst_hold", {25'd0, ready, sout_valid, sout, done, rem}, 32'h40);
      #3 rst_n = 1'b1;
      tick();
      run_frame(8'h07, 3'd0, 3'd0, "post_rst");

      // Every payload value; check field from the model c = -D mod 7.
      for (int d = 0; d < 256; d++) begin
         logic [2:0] r7;
         r7 = 3'(d % 7);
         run_frame(8'(d), 3'((7 - d % 7) % 7), r7, $sformatf("exh%0d", d));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/divisibility_by7_tx.md
# divisibility_by7_tx

Serial frame transmitter for the mod-7 residue link. It accepts a parallel data word, shifts it out MSB-first one bit per clock, and appends a 3-bit check field so the whole frame, read as an unsigned binary number, is divisible by 7. A mod-7 checker at the far end reports remainder 0 after the last bit of every error-free frame.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 1..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset. Asserting it forces the block immediately to IDLE; deassertion is synchronous to `clk`.
- `load`  input  1  request to start a frame. Accepted only on a rising edge where `ready`=1.
- `din`  input  DATA_W  frame payload, sampled on the accepting edge.
- `ready`  output  1  block can accept `load` this cycle.
- `sout`  output  1  serial bit. It is 0 whenever `sout_valid`=0.
- `sout_valid`  output  1  `sout` carries a frame bit this cycle.
- `done`  output  1  one-cycle pulse, coincident with the last bit of the frame.
- `rem`  output  3  running remainder mod 7 of the frame bits already emitted, range 0..6.

## Operation
- The FSM has three states: IDLE, DATA and CHECK. It resets to IDLE.
- **IDLE**
  - `ready`=1.
  - On `load`: capture `din` into the shift register, clear the bit counter and `rem`, then go to DATA.
- **DATA**
  - Emit `shreg[DATA_W-1]`, then shift left.
  - Remainder update per emitted bit b: `rem` <= (2·`rem` + b) mod 7. Compute it in 4 bits and reduce, so values never leave 0..6.
  - After DATA_W bits, latch the check value c = (7 − `rem`) mod 7, range 0..6, then go to CHECK.
- **CHECK**
  - Emit c[2], c[1], c[0] in that order, updating `rem` the same way.
  - After the third bit, `rem`=0 by construction.
- **End of frame and back-to-back frames**
  - `ready` is 1 during the last bit cycle of a frame, as well as in IDLE.
  - If `load` is asserted in the last bit cycle, the next frame's first bit follows on the very next cycle with no gap.
  - Otherwise the FSM returns to IDLE.
- **Boundary conditions**
  - `load` while `ready`=0 is ignored, and `din` is not sampled.
  - `rst_n` asserted mid-frame abandons the frame. The partial frame is not completed and `done` does not pulse.
  - `din`=0 gives check bits 000.
  - Any `din` ≡ 0 (mod 7) gives check bits 000.
- **Reset values:** `ready`=1, `sout`=0, `sout_valid`=0, `done`=0, `rem`=0, shift register 0, counter 0.

## Timing
- **Accept edge** (edge 0): `load`=1 and `ready`=1.
- **Data bits:** cycles 1..DATA_W after the accept edge carry data bits MSB-first, with `sout_valid`=1.
- **Check bits:** cycles DATA_W+1..DATA_W+3 carry the check bits.
- **Frame length:** DATA_W+3 consecutive valid cycles. `sout_valid` never drops mid-frame.
- **`done`:** high exactly in cycle DATA_W+3.
- **`rem`:** registered. In cycle k it reflects bits 1..k−1. It updates on the edge that ends each bit cycle.
- **Latency:** 1 cycle from accept edge to first bit.

## Configuration
- Macro `DIV7_TX_CHECK_EN`.
- **Defined:** behaviour as above; frames are DATA_W+3 bits long.
- **Not defined:**
  - CHECK is not built, so the block is a plain MSB-first serializer with DATA_W-bit frames.
  - `done` and the early `ready` fall on bit DATA_W.
  - `rem` is still computed and reports D mod 7 after the frame.

## Test plan
- **Reset values:** hold `rst_n`=0, then release. Required: `ready`=1, `sout_valid`=0, `sout`=0, `done`=0, `rem`=0. Toggling `clk` with `load`=0 keeps these values.
- **Basic frame:** DATA_W=8, `din`=0x0A.
  - Serial stream is 0000_1010_100 (check value 4); frame value 84 = 12·7.
  - `done` is high in cycle 11; `rem`=0 after the frame.
- **Check value 4 and zero-residue cases:**
  - `din`=0xFF gives check bits 100 (2044 = 292·7).
  - `din`=0x07 gives check bits 000.
  - `din`=0x00 gives all 11 bits 0 with `sout_valid`=1 throughout.
- **Back-to-back frames:** `load` held high with 0x0A, then 0x05.
  - 22 consecutive valid cycles with no gap.
  - Second frame ends with check bits 010 (40+2 = 42).
  - `done` pulses in cycles 11 and 22.
- **Ignored load and reset mid-frame:**
  - Assert `load` with `din`=0x55 in cycle 4 of a frame: ignored, current frame is unchanged.
  - Assert `rst_n`=0 in cycle 6: outputs return to reset values immediately, no `done` pulse; a new `load` then starts cleanly.
- **Exhaustive compare:** for all 256 `din` values, an in-bench mod-7 checker fed `sout`/`sout_valid` reports remainder 0 at every `done`. Without `DIV7_TX_CHECK_EN`, frames are 8 bits and `rem` equals `din` mod 7.
